// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard handshake bundle between the pipeline and hazard_scoreboard_unit.
// Perf counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_scoreboard_if #(
   parameter int REG_W = 5
`ifdef HAZ_PERF_CNT_EN
   , parameter int PERF_W = 32
`endif
);
   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic             id_rs1_used;
   logic [REG_W-1:0] id_rs2;
   logic             id_rs2_used;
   logic [REG_W-1:0] id_rd;
   logic             id_reg_wr;
   logic             id_mem_read;
   logic             id_is_branch;
   logic             cache_miss;
   logic             br_taken;
   logic             stall_if;
   logic             stall_id;
   logic             flush_id;
   logic             flush_ex;
`ifdef HAZ_PERF_CNT_EN
   logic [PERF_W-1:0] perf_miss_stalls;
   logic [PERF_W-1:0] perf_load_stalls;
   logic [PERF_W-1:0] perf_branch_stalls;
   logic [PERF_W-1:0] perf_flushes;
`endif

   modport master (
      output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
             id_reg_wr, id_mem_read, id_is_branch, cache_miss, br_taken,
      input  stall_if, stall_id, flush_id, flush_ex
`ifdef HAZ_PERF_CNT_EN
      , input perf_miss_stalls, perf_load_stalls, perf_branch_stalls, perf_flushes
`endif
   );

   modport slave (
      input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
             id_reg_wr, id_mem_read, id_is_branch, cache_miss, br_taken,
      output stall_if, stall_id, flush_id, flush_ex
`ifdef HAZ_PERF_CNT_EN
      , output perf_miss_stalls, perf_load_stalls, perf_branch_stalls, perf_flushes
`endif
   );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Per-register latency scoreboard driving IF/ID stall, ID flush and EX bubble.
// Define HAZ_PERF_CNT_EN to add stall/flush perf counters and per-register load tags.
module hazard_scoreboard_unit #(
   parameter int NREGS    = 32,
   parameter int REG_W    = 5,
   parameter int CNT_W    = 3,
   parameter int ALU_LAT  = 1,
   parameter int LOAD_LAT = 2
`ifdef HAZ_PERF_CNT_EN
   , parameter int PERF_W = 32
`endif
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave hif
);

   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] thr;
   logic [CNT_W-1:0] cnt_rs1;
   logic [CNT_W-1:0] cnt_rs2;
   logic             haz_rs1;
   logic             haz_rs2;
   logic             hazard;
   logic             stall;
   logic             load_rd;

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction

   // x0 is never tracked, so its lookup is forced to zero.
   function automatic logic [CNT_W-1:0] cnt_of(input logic [REG_W-1:0] idx);
      return (idx == '0) ? '0 : cnt_q[idx];
   endfunction

   // A count of 1 is covered by EX->EX forwarding, except for branches resolved in ID.
   always_comb begin
      thr     = hif.id_is_branch ? '0 : CNT_W'(1);
      cnt_rs1 = cnt_of(hif.id_rs1);
      cnt_rs2 = cnt_of(hif.id_rs2);
      haz_rs1 = hif.id_valid & hif.id_rs1_used & (hif.id_rs1 != '0) & (cnt_rs1 > thr);
      haz_rs2 = hif.id_valid & hif.id_rs2_used & (hif.id_rs2 != '0) & (cnt_rs2 > thr);
      hazard  = haz_rs1 | haz_rs2;
      stall   = hif.cache_miss | hazard;
      load_rd = hif.id_valid & ~stall & hif.id_reg_wr & (hif.id_rd != '0);
   end

   always_comb begin
      hif.stall_if = 1'b0;
      hif.stall_id = 1'b0;
      hif.flush_ex = 1'b0;
      hif.flush_id = 1'b0;
      if (!rst) begin
         hif.stall_if = stall;
         hif.stall_id = stall;
         hif.flush_ex = hazard & ~hif.cache_miss;
         hif.flush_id = hif.br_taken & ~stall;
      end
   end

   // A new producer overwrites any pending count (in-order WAW); a miss freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      end else if (!hif.cache_miss) begin
         for (int r = 1; r < NREGS; r++) begin
            if (load_rd && (hif.id_rd == REG_W'(r)))
               cnt_q[r] <= hif.id_mem_read ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
            else
               cnt_q[r] <= sat_dec(cnt_q[r]);
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic is_load_q [NREGS];
   logic load_stall;

   always_comb begin
      load_stall = ~hif.cache_miss &
                   ((haz_rs1 & is_load_q[hif.id_rs1]) | (haz_rs2 & is_load_q[hif.id_rs2]));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) is_load_q[r] <= 1'b0;
         hif.perf_miss_stalls   <= '0;
         hif.perf_load_stalls   <= '0;
         hif.perf_branch_stalls <= '0;
         hif.perf_flushes       <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (load_rd && (hif.id_rd == REG_W'(r))) is_load_q[r] <= hif.id_mem_read;
         end
         if (hif.cache_miss) hif.perf_miss_stalls <= hif.perf_miss_stalls + PERF_W'(1);
         if (load_stall) hif.perf_load_stalls <= hif.perf_load_stalls + PERF_W'(1);
         if (hazard && !hif.cache_miss && hif.id_is_branch)
            hif.perf_branch_stalls <= hif.perf_branch_stalls + PERF_W'(1);
         if (hif.flush_id) hif.perf_flushes <= hif.perf_flushes + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed table-driven bench for hazard_scoreboard_unit; perf checks only with HAZ_PERF_CNT_EN.
module tb_hazard_scoreboard_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_scoreboard_if hif ();

   hazard_scoreboard_unit dut (
      .clk (clk),
      .rst (rst),
      .hif (hif)
   );

   typedef struct {
      logic       r;
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic       br;
      logic       miss;
      logic       tk;
      logic [3:0] exp;   // {stall_if, stall_id, flush_id, flush_ex}
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(int r, int v, int rs1, int u1, int rs2, int u2, int rd,
                               int wr, int ld, int br, int miss, int tk, int e);
      vec_t t;
      t.r    = 1'(r);
      t.v    = 1'(v);
      t.rs1  = 5'(rs1);
      t.u1   = 1'(u1);
      t.rs2  = 5'(rs2);
      t.u2   = 1'(u2);
      t.rd   = 5'(rd);
      t.wr   = 1'(wr);
      t.ld   = 1'(ld);
      t.br   = 1'(br);
      t.miss = 1'(miss);
      t.tk   = 1'(tk);
      t.exp  = 4'(e);
      return t;
   endfunction

   task automatic apply(input vec_t t, input string name);
      logic [3:0] got;
      @(negedge clk);
      rst              = t.r;
      hif.id_valid     = t.v;
      hif.id_rs1       = t.rs1;
      hif.id_rs1_used  = t.u1;
      hif.id_rs2       = t.rs2;
      hif.id_rs2_used  = t.u2;
      hif.id_rd        = t.rd;
      hif.id_reg_wr    = t.wr;
      hif.id_mem_read  = t.ld;
      hif.id_is_branch = t.br;
      hif.cache_miss   = t.miss;
      hif.br_taken     = t.tk;
      #1;
      got = {hif.stall_if, hif.stall_id, hif.flush_id, hif.flush_ex};
      checks++;
      if (got !== t.exp) begin
         failures++;
         $display("FAIL %s stall_if/stall_id/flush_id/flush_ex got=%b required=%b",
                  name, got, t.exp);
      end
   endtask

   task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, got, exp);
      end
   endtask

   initial begin
      //            r v rs1 u1 rs2 u2 rd wr ld br ms tk exp
      tbl.push_back(mk(1,1, 5,1, 0,0, 6,1,0,0,0,0,4'b0000)); // reset forces outputs low
      tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0,0,0,4'b0000));
      tbl.push_back(mk(0,1, 1,1, 0,0, 5,1,1,0,0,0,4'b0000)); // lw x5
      tbl.push_back(mk(0,1, 5,1, 1,1, 6,1,0,0,0,0,4'b1101)); // add x6,x5,x1: load-use stall
      tbl.push_back(mk(0,1, 5,1, 1,1, 6,1,0,0,0,0,4'b0000));
      tbl.push_back(mk(0,1, 1,1, 2,1, 5,1,0,0,0,0,4'b0000)); // add x5
      tbl.push_back(mk(0,1, 5,1, 0,1, 0,0,0,1,0,0,4'b1101)); // beq x5,x0: 1 stall
      tbl.push_back(mk(0,1, 5,1, 0,1, 0,0,0,1,0,1,4'b0010)); // taken, no hazard -> flush_id
      tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1,0,0,0,4'b0000)); // lw x5
      tbl.push_back(mk(0,1, 5,1, 0,1, 0,0,0,1,0,1,4'b1101)); // beq x5: 2 stalls, no flush
      tbl.push_back(mk(0,1, 5,1, 0,1, 0,0,0,1,0,1,4'b1101));
      tbl.push_back(mk(0,1, 5,1, 0,1, 0,0,0,1,0,1,4'b0010));
      tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1,0,0,0,4'b0000)); // lw x5
      tbl.push_back(mk(0,1, 5,0, 0,0, 7,1,0,0,0,0,4'b0000)); // rs1=x5 unused
      tbl.push_back(mk(0,1, 0,0, 0,0, 0,1,1,0,0,0,4'b0000)); // lw x0
      tbl.push_back(mk(0,1, 0,1, 0,1, 0,0,0,1,0,0,4'b0000)); // branch reading x0
      tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,1,0,0,0,4'b0000)); // lw x8
      tbl.push_back(mk(0,0, 8,1, 8,1, 9,1,0,1,0,0,4'b0000)); // id_valid=0: no stall
      tbl.push_back(mk(0,1, 8,1, 8,1, 9,1,0,0,0,0,4'b0000)); // rs1==rs2, cnt=1 forwardable
      tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1,0,0,0,4'b0000)); // lw x5 then 3-cycle miss
      tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,0,0,1,0,4'b1100));
      tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,0,0,1,0,4'b1100));
      tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,0,0,1,1,4'b1100));
      tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,0,0,0,0,4'b1101)); // count held at 2
      tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,0,0,0,0,4'b0000));
      tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1,0,0,0,4'b0000)); // lw x5
      tbl.push_back(mk(1,1, 5,1, 0,0, 6,1,0,0,0,0,4'b0000)); // rst over load-use stall
      tbl.push_back(mk(0,1, 5,1, 0,1, 0,0,0,1,0,0,4'b0000)); // beq x5 after rst: clear
      tbl.push_back(mk(0,1, 0,0, 0,0,10,1,0,0,0,0,4'b0000)); // add x10
      tbl.push_back(mk(0,1, 0,0, 0,0,10,1,1,0,0,0,4'b0000)); // lw x10 overwrites
      tbl.push_back(mk(0,1,10,1, 0,0,11,1,0,0,0,0,4'b1101));
      tbl.push_back(mk(0,1,10,1, 0,0,11,1,0,0,0,0,4'b0000));
      tbl.push_back(mk(0,1, 0,0, 0,0,12,1,1,0,0,0,4'b0000)); // lw x12, rs2 consumer
      tbl.push_back(mk(0,1, 0,1,12,1,13,1,0,0,0,0,4'b1101));
      tbl.push_back(mk(0,1, 0,1,12,1,13,1,0,0,0,0,4'b0000));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

      // Reset dominates a concurrent miss; ALU->ALU chains never stall.
      apply(mk(1,1, 0,0, 0,0, 0,0,0,0,1,1,4'b0000), "rst_over_miss");
      apply(mk(0,1, 1,1, 2,1, 3,1,0,0,0,0,4'b0000), "alu_x3");
      apply(mk(0,1, 3,1, 3,1, 4,1,0,0,0,0,4'b0000), "alu_use_x3");
      apply(mk(0,1, 4,1, 0,1, 0,0,0,1,0,0,4'b1101), "alu_branch_x4");
      apply(mk(0,1, 4,1, 0,1, 0,0,0,1,0,0,4'b0000), "alu_branch_x4_go");

`ifdef HAZ_PERF_CNT_EN
      apply(mk(1,0, 0,0, 0,0, 0,0,0,0,0,0,4'b0000), "perf_rst");
      @(posedge clk); #1;
      chk_val("perf_rst_load", hif.perf_load_stalls, 0);
      chk_val("perf_rst_branch", hif.perf_branch_stalls, 0);
      apply(mk(0,1, 0,0, 0,0, 5,1,1,0,0,0,4'b0000), "perf_lw");
      apply(mk(0,1, 5,1, 1,1, 6,1,0,0,0,0,4'b1101), "perf_use");
      apply(mk(0,1, 5,1, 1,1, 6,1,0,0,0,0,4'b0000), "perf_use_go");
      @(posedge clk); #1;
      chk_val("perf_load_stalls_1", hif.perf_load_stalls, 1);
      chk_val("perf_branch_stalls_0", hif.perf_branch_stalls, 0);
      chk_val("perf_miss_stalls_0", hif.perf_miss_stalls, 0);
      apply(mk(0,0, 0,0, 0,0, 0,0,0,0,1,0,4'b1100), "perf_miss");
      apply(mk(0,1, 0,0, 0,0, 5,1,1,0,0,0,4'b0000), "perf_lw2");
      apply(mk(0,1, 5,1, 0,1, 0,0,0,1,0,1,4'b1101), "perf_br_a");
      apply(mk(0,1, 5,1, 0,1, 0,0,0,1,0,1,4'b1101), "perf_br_b");
      apply(mk(0,1, 5,1, 0,1, 0,0,0,1,0,1,4'b0010), "perf_br_go");
      @(posedge clk); #1;
      chk_val("perf_miss_stalls", hif.perf_miss_stalls, 1);
      chk_val("perf_load_stalls", hif.perf_load_stalls, 3);
      chk_val("perf_branch_stalls", hif.perf_branch_stalls, 2);
      chk_val("perf_flushes", hif.perf_flushes, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
